// File: rtl/sine_dds_reader.sv
// Full-wave sine DDS front end: phase accumulator, quarter-wave LUT addressing
// with mirroring, and sign/peak reconstruction into a registered signed sample.
module sine_dds_reader #(
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               phase_load,
  input  logic [PHASE_W-1:0] phase_in,
  output logic [9:0]         lut_addr,
  input  logic [22:0]        lut_data,
  output logic [23:0]        sin_out,
  output logic               out_valid
);

  logic [PHASE_W-1:0] phase_acc;
  logic [1:0]         quad;
  logic [9:0]         idx;
  logic               pk_c;
  logic               neg;
  logic               pk;
  logic               v1;
  logic [22:0]        mag;

  assign quad = phase_acc[PHASE_W-1 -: 2];
  assign idx  = phase_acc[PHASE_W-3 -: 10];

  // Odd quadrants run the table backwards; i=0 there is the pi/2 peak,
  // which lies one entry past the end of the quarter-wave table.
  always_comb begin
    pk_c     = 1'b0;
    lut_addr = idx;
    if (quad[0]) begin
      pk_c     = (idx == 10'd0);
      lut_addr = pk_c ? 10'd0 : (10'd0 - idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_acc <= '0;
      neg       <= 1'b0;
      pk        <= 1'b0;
      v1        <= 1'b0;
    end else if (phase_load) begin
      phase_acc <= phase_in;
      v1        <= 1'b0;
    end else if (en) begin
      neg       <= quad[1];
      pk        <= pk_c;
      v1        <= 1'b1;
      phase_acc <= phase_acc + phase_inc;
    end else begin
      v1        <= 1'b0;
    end
  end

  assign mag = pk ? 23'h7FFFFF : lut_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_out   <= 24'h000000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) sin_out <= neg ? (24'd0 - {1'b0, mag}) : {1'b0, mag};
    end
  end

endmodule

// File: tb/tb_sine_dds_reader.sv
// Bench for sine_dds_reader: directed corner cases plus randomized streaming
// against a model that evaluates the sine of the truncated phase angle directly.
module tb_sine_dds_reader;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] phase_inc = '0;
  logic        phase_load = 1'b0;
  logic [31:0] phase_in = '0;
  logic [9:0]  lut_addr;
  logic [22:0] lut_data;
  logic [23:0] sin_out;
  logic        out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_phase = '0;
  logic        m_pend_v = 1'b0;
  logic [23:0] m_pend_val = '0;
  logic        m_valid = 1'b0;
  logic [23:0] m_out = '0;

  always #5 clk = ~clk;

  sine_dds_reader #(.PHASE_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_inc(phase_inc),
    .phase_load(phase_load), .phase_in(phase_in), .lut_addr(lut_addr),
    .lut_data(lut_data), .sin_out(sin_out), .out_valid(out_valid)
  );

  // quarter-wave LUT with registered address
  function automatic logic [22:0] lut_fn(input logic [9:0] j);
    int v;
    v = $rtoi(8388608.0 * $sin(PI / 2.0 * real'(j) / 1024.0) + 0.5);
    if (v > 32'h7FFFFF) v = 32'h7FFFFF;
    return 23'(v);
  endfunction

  logic [9:0] lut_q = '0;
  always @(posedge clk) lut_q <= lut_addr;
  assign lut_data = lut_fn(lut_q);

  // full-circle sine of the 12-bit truncated phase, magnitude clamped to 23 bits
  function automatic logic [23:0] ref_sample(input logic [31:0] p);
    int  k, mag;
    real s, a;
    k = int'(p[31:20]);
    s = $sin(2.0 * PI * real'(k) / 4096.0);
    a = (s < 0.0) ? -s : s;
    mag = $rtoi(a * 8388608.0 + 0.5);
    if (mag > 32'h7FFFFF) mag = 32'h7FFFFF;
    return (s < 0.0) ? 24'(-mag) : 24'(mag);
  endfunction

  function automatic logic [9:0] ref_addr(input logic [31:0] p);
    int i;
    i = int'(p[29:20]);
    if (p[30]) return (i == 0) ? 10'd0 : 10'(1024 - i);
    return 10'(i);
  endfunction

  // one clock: drive inputs, advance the model at the edge, return at negedge
  task automatic cyc(input logic ld, input logic [31:0] pin, input logic e);
    phase_load = ld;
    phase_in   = pin;
    en         = e;
    @(posedge clk);
    m_valid = m_pend_v;
    if (m_pend_v) m_out = m_pend_val;
    if (ld) begin
      m_pend_v = 1'b0;
      m_phase  = pin;
    end else if (e) begin
      m_pend_v   = 1'b1;
      m_pend_val = ref_sample(m_phase);
      m_phase    = m_phase + phase_inc;
    end else begin
      m_pend_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_phase = '0; m_pend_v = 1'b0; m_valid = 1'b0; m_out = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (sin_out !== 24'h0) begin n_bad++; $display("FAIL reset_sin_out got %h want 000000", sin_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (lut_addr !== 10'h0) begin n_bad++; $display("FAIL reset_addr got %h want 000", lut_addr); end
    n_cmp++; if (dut.phase_acc !== 32'h0) begin n_bad++; $display("FAIL reset_phase got %h want 0", dut.phase_acc); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    logic [23:0] want [3];
    want[0] = 24'h000000; want[1] = 24'h003244; want[2] = 24'h006488;
    phase_inc = 32'h0010_0000;
    cyc(1'b1, 32'h0, 1'b0);
    n_cmp++; if (lut_addr !== 10'd0) begin n_bad++; $display("FAIL ramp_addr0 got %h want 000", lut_addr); end
    cyc(1'b0, 32'h0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_early_valid got %b want 0", out_valid); end
    for (int n = 0; n < 3; n++) begin
      n_cmp++; if (lut_addr !== 10'(n + 1)) begin n_bad++; $display("FAIL ramp_addr got %h want %h", lut_addr, 10'(n + 1)); end
      cyc(1'b0, 32'h0, 1'b1);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ramp_valid got %b want 1", out_valid); end
      n_cmp++; if (sin_out !== want[n]) begin n_bad++; $display("FAIL ramp_sample got %h want %h", sin_out, want[n]); end
    end
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
  endtask

  task automatic single_shot(input logic [31:0] p, input logic [23:0] want, input string name);
    cyc(1'b1, p, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || sin_out !== want) begin
      n_bad++; $display("FAIL %s got valid=%b sin=%h want valid=1 sin=%h", name, out_valid, sin_out, want);
    end
    cyc(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_peak_and_sign();
    phase_inc = 32'h0010_0000;
    cyc(1'b1, 32'h4010_0000, 1'b0);
    n_cmp++; if (lut_addr !== 10'h3FF) begin n_bad++; $display("FAIL mirror_addr got %h want 3ff", lut_addr); end
    single_shot(32'h4000_0000, 24'h7FFFFF, "pos_peak");
    single_shot(32'h4010_0000, 24'h7FFFF6, "mirror_3ff");
    single_shot(32'h8010_0000, 24'hFFCDBC, "neg_q2");
    single_shot(32'hC000_0000, 24'h800001, "neg_peak");
    single_shot(32'h8000_0000, 24'h000000, "neg_zero");
  endtask

  task automatic test_wrap();
    phase_inc = 32'h0010_0000;
    cyc(1'b1, 32'hFFF0_0000, 1'b0);
    n_cmp++; if (lut_addr !== 10'd1) begin n_bad++; $display("FAIL wrap_addr got %h want 001", lut_addr); end
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    n_cmp++; if (sin_out !== 24'hFFCDBC) begin n_bad++; $display("FAIL wrap_q3 got %h want ffcdbc", sin_out); end
    cyc(1'b0, 32'h0, 1'b0);
    n_cmp++; if (sin_out !== 24'h000000 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL wrap_zero got %h/%b want 000000/1", sin_out, out_valid);
    end
    n_cmp++; if (dut.phase_acc !== 32'h0010_0000) begin n_bad++; $display("FAIL wrap_phase got %h want 00100000", dut.phase_acc); end
  endtask

  task automatic test_load_priority();
    logic [23:0] held;
    phase_inc = 32'h0123_4567;
    cyc(1'b1, 32'h1234_5678, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL load_prio_valid got %b want 0", out_valid); end
    cyc(1'b0, 32'h0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || sin_out !== ref_sample(32'h1234_5678)) begin
      n_bad++; $display("FAIL load_prio_sample got %h/%b want %h/1", sin_out, out_valid, ref_sample(32'h1234_5678));
    end
    held = sin_out;
    cyc(1'b0, 32'h0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || sin_out !== held) begin
      n_bad++; $display("FAIL hold_idle got %h/%b want %h/0", sin_out, out_valid, held);
    end
    cyc(1'b0, 32'h0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || sin_out !== m_out) begin
      n_bad++; $display("FAIL toggle_sample got %h/%b want %h/1", sin_out, out_valid, m_out);
    end
  endtask

  task automatic test_reset_mid();
    phase_inc = 32'h0200_0000;
    cyc(1'b1, 32'h2000_0000, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    n_cmp++; if (sin_out === 24'h0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_stream got %h/%b want nonzero/1", sin_out, out_valid);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (sin_out !== 24'h0 || out_valid !== 1'b0 || dut.phase_acc !== 32'h0) begin
      n_bad++; $display("FAIL async_reset got %h/%b/%h want 000000/0/0", sin_out, out_valid, dut.phase_acc);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, 32'h0, 1'b0);
      n_cmp++; if (out_valid !== 1'b0 || sin_out !== 24'h0) begin
        n_bad++; $display("FAIL stale_after_reset got %h/%b want 000000/0", sin_out, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic        ld, e;
    logic [31:0] pin;
    phase_inc = $urandom;
    cyc(1'b1, $urandom, 1'b0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) phase_inc = $urandom;
      ld  = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 3) != 0);
      pin = $urandom;
      n_cmp++; if (lut_addr !== ref_addr(m_phase)) begin
        n_bad++; $display("FAIL rand_addr phase=%h got %h want %h", m_phase, lut_addr, ref_addr(m_phase));
      end
      cyc(ld, pin, e);
      n_cmp++; if (out_valid !== m_valid || sin_out !== m_out) begin
        n_bad++; $display("FAIL rand_out got %h/%b want %h/%b", sin_out, out_valid, m_out, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_peak_and_sign();
    test_wrap();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
